add_round_key_gen: RTL and testbench

- Parametrised next-generation AES AddRoundKey engine for the unrolled encrypt datapath.
- XORs the 4 x NB byte state held in the external dual-port statemt memory with round key n, read from an external dual-port round-key memory.
- The round-key memory is external rather than an embedded table, so NB, round count and key layout are set by parameters.
- Uses the ap_start/ap_done/ap_idle/ap_ready block-level handshake.

---
 rtl/add_round_key_gen.sv | 159 +++++++++++++++
 tb/tb_add_round_key_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_round_key_gen.sv
// add_round_key_gen: AES AddRoundKey engine, XORs the 4 x NB statemt memory with round key n.
//   Build option: define ROUND_RANGE_CHECK_EN to reject round indices above NR (key_err).
//   Ports:
//     ap_clk, ap_rst_n                  clock, asynchronous active-low reset
//     ap_start/ap_done/ap_idle/ap_ready block-level handshake
//     n                                 round index, sampled when a start is accepted
//     statemt_*0/1                      dual-port state memory (1-cycle read latency)
//     key_*0/1                          dual-port round-key memory (1-cycle read latency)
//     key_err                           round index out of range, valid with ap_done
module add_round_key_gen #(
   parameter int NB             = 4,
   parameter int DATA_W         = 32,
   parameter int KEY_W          = 8,
   parameter int NR             = 14,
   parameter int ST_AW          = 5,
   parameter int KEY_AW         = 9,
   parameter int KEY_ROW_STRIDE = 120
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              ap_start,
   output logic              ap_done,
   output logic              ap_idle,
   output logic              ap_ready,
   input  logic [31:0]       n,
   output logic [ST_AW-1:0]  statemt_address0,
   output logic              statemt_ce0,
   output logic              statemt_we0,
   output logic [DATA_W-1:0] statemt_d0,
   input  logic [DATA_W-1:0] statemt_q0,
   output logic [ST_AW-1:0]  statemt_address1,
   output logic              statemt_ce1,
   output logic              statemt_we1,
   output logic [DATA_W-1:0] statemt_d1,
   input  logic [DATA_W-1:0] statemt_q1,
   output logic [KEY_AW-1:0] key_address0,
   output logic              key_ce0,
   input  logic [KEY_W-1:0]  key_q0,
   output logic [KEY_AW-1:0] key_address1,
   output logic              key_ce1,
   input  logic [KEY_W-1:0]  key_q1,
   output logic              key_err
);
   localparam int JW = $clog2(NB + 1);
   typedef enum logic [2:0] {S_IDLE, S_COL, S_RD, S_WR0, S_WR1} state_t;
   state_t state, state_nx;
   logic [JW-1:0] j;
   logic [31:0] n_reg, key_base;
   logic [DATA_W-1:0] st0, st1, r2, r3;
   logic [KEY_W-1:0] k0, k1;
   logic err, bad, fin, st_en, key_en, hi;
   if (NB < 1 || NB > 8 || 4 * NB > 2 ** ST_AW || NR < 0) begin : g_bad_cfg
      $error("add_round_key_gen: illegal NB/ST_AW/NR combination");
   end
`ifdef ROUND_RANGE_CHECK_EN
   assign bad = n > 32'(NR);
`else
   assign bad = 1'b0;
`endif
   assign fin = j == JW'(NB);
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) state <= S_IDLE;
      else state <= state_nx;
   // hi selects rows 2/3 of the current column (S_RD reads, S_WR1 writes)
   always_comb begin
      state_nx    = state;
      ap_idle     = 1'b0;
      ap_done     = 1'b0;
      ap_ready    = 1'b0;
      key_err     = 1'b0;
      st_en       = 1'b0;
      key_en      = 1'b0;
      hi          = 1'b0;
      statemt_we0 = 1'b0;
      statemt_we1 = 1'b0;
      case (state)
         S_IDLE: begin
            ap_idle = !ap_start;
            if (ap_start) state_nx = S_COL;
         end
         S_COL: begin
            if (fin) begin
               ap_done  = 1'b1;
               ap_ready = 1'b1;
               key_err  = err;
               state_nx = S_IDLE;
            end else begin
               st_en    = 1'b1;
               key_en   = 1'b1;
               state_nx = S_RD;
            end
         end
         S_RD: begin
            st_en    = 1'b1;
            key_en   = 1'b1;
            hi       = 1'b1;
            state_nx = S_WR0;
         end
         S_WR0: begin
            st_en       = 1'b1;
            statemt_we0 = 1'b1;
            statemt_we1 = 1'b1;
            state_nx    = S_WR1;
         end
         S_WR1: begin
            st_en       = 1'b1;
            hi          = 1'b1;
            statemt_we0 = 1'b1;
            statemt_we1 = 1'b1;
            state_nx    = S_COL;
         end
         default: state_nx = S_IDLE;
      endcase
   end
   assign statemt_ce0      = st_en;
   assign statemt_ce1      = st_en;
   assign key_ce0          = key_en;
   assign key_ce1          = key_en;
   // element (r, j) lives at 4*j + r
   assign statemt_address0 = st_en ? ST_AW'({j, hi, 1'b0}) : '0;
   assign statemt_address1 = st_en ? ST_AW'({j, hi, 1'b1}) : '0;
   // key address wraps naturally by truncation to KEY_AW
   assign key_base         = n_reg * 32'(NB) + 32'(j);
   assign key_address0     = key_en ? KEY_AW'(key_base + 32'(hi ? 2 * KEY_ROW_STRIDE : 0)) : '0;
   assign key_address1     = key_en ? KEY_AW'(key_base + 32'(hi ? 3 * KEY_ROW_STRIDE : KEY_ROW_STRIDE)) : '0;
   assign statemt_d0       = statemt_we0 ? (hi ? r2 : st0 ^ DATA_W'(k0)) : '0;
   assign statemt_d1       = statemt_we1 ? (hi ? r3 : st1 ^ DATA_W'(k1)) : '0;
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         j     <= '0;
         n_reg <= '0;
         err   <= 1'b0;
         st0   <= '0;
         st1   <= '0;
         k0    <= '0;
         k1    <= '0;
         r2    <= '0;
         r3    <= '0;
      end else begin
         // an out-of-range round jumps straight to the done column
         if (state == S_IDLE && ap_start) begin
            n_reg <= n;
            j     <= bad ? JW'(NB) : '0;
            err   <= bad;
         end
         if (state == S_RD) begin
            st0 <= statemt_q0;
            st1 <= statemt_q1;
            k0  <= key_q0;
            k1  <= key_q1;
         end
         // rows 2/3 data arrives while rows 0/1 are being written; hold it for S_WR1
         if (state == S_WR0) begin
            r2 <= statemt_q0 ^ DATA_W'(key_q0);
            r3 <= statemt_q1 ^ DATA_W'(key_q1);
         end
         if (state == S_WR1) j <= j + JW'(1);
      end
endmodule

// File: tb/tb_add_round_key_gen.sv
// tb_add_round_key_gen: scoreboard bench for add_round_key_gen (NB=4 and NB=6 instances)
module tb_add_round_key_gen;
   typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
   logic ap_clk = 1'b0, ap_rst_n = 1'b1, init_mem = 1'b0;
   logic a_start = 1'b0, b_start = 1'b0;
   logic [31:0] n_a = '0, n_b = '0;
   int cyc = 0, tests = 0, fails = 0;
   int a_wrcnt = 0, b_wrcnt = 0, a_dcnt = 0, b_dcnt = 0;
   logic a_anyce = 1'b0, b_anyce = 1'b0;
   logic [31:0] stm_a [32], stm_b [32], mdl_a [32], mdl_b [32];
   logic [7:0] keym [512];
   wr_t wq_a [$], wq_b [$];
   logic [8:0] kq_a [$], kq_b [$];
   logic a_done, a_idle, a_ready, a_kerr, b_done, b_idle, b_ready, b_kerr;
   logic [4:0] a_sa0, a_sa1, b_sa0, b_sa1;
   logic a_sce0, a_sce1, a_swe0, a_swe1, b_sce0, b_sce1, b_swe0, b_swe1;
   logic [31:0] a_sd0, a_sd1, a_sq0, a_sq1, b_sd0, b_sd1, b_sq0, b_sq1;
   logic [8:0] a_ka0, a_ka1, b_ka0, b_ka1;
   logic a_kce0, a_kce1, b_kce0, b_kce1;
   logic [7:0] a_kq0, a_kq1, b_kq0, b_kq1;
   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;
   add_round_key_gen u_a (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(a_start), .ap_done(a_done),
      .ap_idle(a_idle), .ap_ready(a_ready), .n(n_a),
      .statemt_address0(a_sa0), .statemt_ce0(a_sce0), .statemt_we0(a_swe0),
      .statemt_d0(a_sd0), .statemt_q0(a_sq0),
      .statemt_address1(a_sa1), .statemt_ce1(a_sce1), .statemt_we1(a_swe1),
      .statemt_d1(a_sd1), .statemt_q1(a_sq1),
      .key_address0(a_ka0), .key_ce0(a_kce0), .key_q0(a_kq0),
      .key_address1(a_ka1), .key_ce1(a_kce1), .key_q1(a_kq1), .key_err(a_kerr)
   );
   add_round_key_gen #(.NB(6)) u_b (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(b_start), .ap_done(b_done),
      .ap_idle(b_idle), .ap_ready(b_ready), .n(n_b),
      .statemt_address0(b_sa0), .statemt_ce0(b_sce0), .statemt_we0(b_swe0),
      .statemt_d0(b_sd0), .statemt_q0(b_sq0),
      .statemt_address1(b_sa1), .statemt_ce1(b_sce1), .statemt_we1(b_swe1),
      .statemt_d1(b_sd1), .statemt_q1(b_sq1),
      .key_address0(b_ka0), .key_ce0(b_kce0), .key_q0(b_kq0),
      .key_address1(b_ka1), .key_ce1(b_kce1), .key_q1(b_kq1), .key_err(b_kerr)
   );
   always @(posedge ap_clk) begin
      if (init_mem) begin
         for (int i = 0; i < 32; i++) begin
            stm_a[i] <= 32'(i);
            stm_b[i] <= 32'hA5A5_0000 | 32'(i);
         end
      end else begin
         if (a_sce0) begin
            if (a_swe0) stm_a[a_sa0] <= a_sd0;
            a_sq0 <= stm_a[a_sa0];
         end
         if (a_sce1) begin
            if (a_swe1) stm_a[a_sa1] <= a_sd1;
            a_sq1 <= stm_a[a_sa1];
         end
         if (b_sce0) begin
            if (b_swe0) stm_b[b_sa0] <= b_sd0;
            b_sq0 <= stm_b[b_sa0];
         end
         if (b_sce1) begin
            if (b_swe1) stm_b[b_sa1] <= b_sd1;
            b_sq1 <= stm_b[b_sa1];
         end
      end
      if (a_kce0) a_kq0 <= keym[a_ka0];
      if (a_kce1) a_kq1 <= keym[a_ka1];
      if (b_kce0) b_kq0 <= keym[b_ka0];
      if (b_kce1) b_kq1 <= keym[b_ka1];
   end
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic mdl_init();
      for (int i = 0; i < 32; i++) begin
         mdl_a[i] = 32'(i);
         mdl_b[i] = 32'hA5A5_0000 | 32'(i);
      end
   endtask
   // expected writes and key reads, in the order the engine issues them
   task automatic push_op(input int u, input logic [31:0] nv);
      int nb;
      logic [8:0] ka;
      logic [4:0] sa;
      logic [31:0] dv;
      nb = u ? 6 : 4;
      for (int j = 0; j < nb; j++)
         for (int r = 0; r < 4; r++) begin
            ka = 9'(32'(r * 120 + j) + nv * 32'(nb));
            sa = 5'(4 * j + r);
            if (u != 0) begin
               dv = mdl_b[sa] ^ {24'b0, keym[ka]};
               mdl_b[sa] = dv;
               wq_b.push_back({sa, dv});
               kq_b.push_back(ka);
            end else begin
               dv = mdl_a[sa] ^ {24'b0, keym[ka]};
               mdl_a[sa] = dv;
               wq_a.push_back({sa, dv});
               kq_a.push_back(ka);
            end
         end
   endtask
   task automatic pop_wr(input int u, input logic [4:0] a, input logic [31:0] d);
      wr_t e;
      int sz;
      sz = u ? wq_b.size() : wq_a.size();
      tests++;
      assert (sz != 0) else begin
         fails++;
         $error("FAIL wr_extra: observed write to %0d expected no write", a);
      end
      if (sz != 0) begin
         if (u != 0) e = wq_b.pop_front();
         else e = wq_a.pop_front();
         chk("wr_addr", a, e.a);
         chk("wr_data", d, e.d);
      end
   endtask
   task automatic pop_key(input int u, input logic [8:0] a);
      int sz;
      sz = u ? kq_b.size() : kq_a.size();
      tests++;
      assert (sz != 0) else begin
         fails++;
         $error("FAIL key_extra: observed key read %0d expected none", a);
      end
      if (sz != 0) begin
         if (u != 0) chk("key_addr", a, kq_b.pop_front());
         else chk("key_addr", a, kq_a.pop_front());
      end
   endtask
   always @(negedge ap_clk) begin
      if (a_swe0) pop_wr(0, a_sa0, a_sd0);
      if (a_swe1) pop_wr(0, a_sa1, a_sd1);
      if (a_kce0) pop_key(0, a_ka0);
      if (a_kce1) pop_key(0, a_ka1);
      if (b_swe0) pop_wr(1, b_sa0, b_sd0);
      if (b_swe1) pop_wr(1, b_sa1, b_sd1);
      if (b_kce0) pop_key(1, b_ka0);
      if (b_kce1) pop_key(1, b_ka1);
      a_wrcnt += int'(a_swe0) + int'(a_swe1);
      b_wrcnt += int'(b_swe0) + int'(b_swe1);
      if (a_sce0 | a_sce1 | a_kce0 | a_kce1) a_anyce = 1'b1;
      if (b_sce0 | b_sce1 | b_kce0 | b_kce1) b_anyce = 1'b1;
      if (a_done) a_dcnt++;
      if (b_done) b_dcnt++;
   end
   task automatic mem_check(input int u);
      for (int i = 0; i < 32; i++)
         chk(u ? "mem_b" : "mem_a", u ? stm_b[i] : stm_a[i], u ? mdl_b[i] : mdl_a[i]);
   endtask
   task automatic run_op(input int u, input logic [31:0] nv, input int lat, input logic err, input int nwr);
      int c0;
      logic seen;
      if (nwr > 0) push_op(u, nv);
      if (u != 0) begin
         b_wrcnt = 0; b_anyce = 1'b0; n_b = nv; b_start = 1'b1;
      end else begin
         a_wrcnt = 0; a_anyce = 1'b0; n_a = nv; a_start = 1'b1;
      end
      c0 = cyc;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge ap_clk);
         a_start = 1'b0;
         b_start = 1'b0;
         if (u ? b_done : a_done) begin
            seen = 1'b1;
            chk("latency", cyc - c0, lat);
            chk("ready", u ? b_ready : a_ready, 1);
            chk("key_err", u ? b_kerr : a_kerr, err);
         end
      end
      chk("done_seen", seen, 1);
      @(negedge ap_clk);
      chk("done_pulse", u ? b_done : a_done, 0);
      chk("writes", u ? b_wrcnt : a_wrcnt, nwr);
      chk("any_ce", u ? b_anyce : a_anyce, nwr > 0);
      chk("wq_left", u ? wq_b.size() : wq_a.size(), 0);
      chk("kq_left", u ? kq_b.size() : kq_a.size(), 0);
      mem_check(u);
   endtask
   initial begin
      int nd, dn;
      int dc [3];
      logic idle_hit;
      for (int a = 0; a < 512; a++) keym[a] = 8'((a / 120) * 16 + a % 120);
      #1 ap_rst_n = 1'b0;
      @(negedge ap_clk);
      chk("rst_en", {a_sce0, a_sce1, a_swe0, a_swe1, a_kce0, a_kce1}, 0);
      chk("rst_addr", {a_sa0, a_sa1, a_ka0, a_ka1}, 0);
      chk("rst_d", {a_sd0, a_sd1}, 0);
      chk("rst_hs", {a_done, a_ready, a_kerr}, 0);
      chk("rst_idle", a_idle, 1);
      a_start = 1'b1;
      #1 chk("rst_idle_start", a_idle, 0);
      a_start = 1'b0;
      init_mem = 1'b1;
      @(negedge ap_clk);
      init_mem = 1'b0;
      mdl_init();
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      chk("idle_after_rst", a_idle, 1);
      run_op(0, 0, 17, 1'b0, 16);
      run_op(0, 2, 17, 1'b0, 16);
      push_op(0, 1);
      push_op(0, 1);
      push_op(0, 1);
      a_wrcnt = 0;
      idle_hit = 1'b0;
      nd = 0;
      n_a = 1;
      a_start = 1'b1;
      for (int i = 0; i < 200 && nd < 3; i++) begin
         @(negedge ap_clk);
         if (a_idle) idle_hit = 1'b1;
         if (a_done) begin
            dc[nd] = cyc;
            nd++;
         end else if (nd == 2 && cyc == dc[1] + 2) a_start = 1'b0;
      end
      chk("held_ops", nd, 3);
      chk("held_gap1", dc[1] - dc[0], 18);
      chk("held_gap2", dc[2] - dc[1], 18);
      chk("held_idle", idle_hit, 0);
      @(negedge ap_clk);
      chk("held_end", a_done, 0);
      chk("held_writes", a_wrcnt, 48);
      chk("held_wq", wq_a.size(), 0);
      mem_check(0);
      push_op(0, 0);
      n_a = 0;
      a_start = 1'b1;
      @(negedge ap_clk);
      a_start = 1'b0;
      repeat (5) @(negedge ap_clk);
      dn = a_dcnt;
      #2 ap_rst_n = 1'b0;
      #1 chk("abort_en", {a_sce0, a_sce1, a_swe0, a_swe1, a_kce0, a_kce1}, 0);
      chk("abort_done", a_done, 0);
      wq_a.delete();
      kq_a.delete();
      init_mem = 1'b1;
      @(negedge ap_clk);
      init_mem = 1'b0;
      mdl_init();
      repeat (2) @(negedge ap_clk);
      chk("abort_no_done", a_dcnt, dn);
      ap_rst_n = 1'b1;
      @(negedge ap_clk);
      run_op(0, 0, 17, 1'b0, 16);
      run_op(1, 3, 25, 1'b0, 24);
`ifdef ROUND_RANGE_CHECK_EN
      run_op(0, 15, 1, 1'b1, 0);
`else
      run_op(0, 15, 17, 1'b0, 16);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
